// File: rtl/instruction_decoder.sv
// 6502 opcode decoder: one-cycle datapath control pulse per instruction_ready rise.
// Optional DECODER_ILLEGAL_TRAP_EN adds sticky illegal / illegal_addr outputs.
module instruction_decoder #(
    parameter int ADDR_WIDTH = 16,
    parameter int REG_WIDTH  = 8,
    parameter int WE_WIDTH   = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instruction_ready,
    input  logic [REG_WIDTH-1:0]  instruction_in,
    input  logic [ADDR_WIDTH-1:0] address_in,
    output logic [REG_WIDTH-1:0]  opp,
    output logic [WE_WIDTH-1:0]   we,
    output logic [2:0]            source_selector_0,
    output logic [2:0]            source_selector_1,
    output logic [2:0]            target_selector_0,
    output logic [2:0]            target_selector_1,
`ifdef DECODER_ILLEGAL_TRAP_EN
    output logic                  illegal,
    output logic [ADDR_WIDTH-1:0] illegal_addr,
`endif
    output logic                  instruction_done
);

    localparam int WE_ADD  = 2;
    localparam int WE_X    = 3;
    localparam int WE_Y    = 4;
    localparam int WE_STAT = 5;
    localparam int WE_DOUT = 6;

    localparam logic [2:0] SRC_ADD  = 3'd1;
    localparam logic [2:0] SRC_X    = 3'd2;
    localparam logic [2:0] SRC_Y    = 3'd3;
    localparam logic [2:0] SRC_IMM  = 3'd4;
    localparam logic [2:0] SRC_MEM  = 3'd5;
    localparam logic [2:0] SRC_ZERO = 3'd6;

    localparam logic [2:0] TGT_ADD  = 3'd1;
    localparam logic [2:0] TGT_X    = 3'd2;
    localparam logic [2:0] TGT_Y    = 3'd3;
    localparam logic [2:0] TGT_NONE = 3'd4;
    localparam logic [2:0] TGT_MEM  = 3'd5;

    typedef enum logic {IDLE, EXEC} state_e;

    state_e                state_q, state_d;
    logic                  ready_prev_q;
    logic [REG_WIDTH-1:0]  opp_q, opp_d;
    logic [WE_WIDTH-1:0]   we_q, we_d;
    logic [2:0]            s0_q, s0_d, s1_q, s1_d;
    logic [2:0]            t0_q, t0_d, t1_q, t1_d;
    logic                  done_q, done_d;

    logic [WE_WIDTH-1:0]   dec_we;
    logic [2:0]            dec_s0, dec_s1, dec_t0, dec_t1;
    logic                  dec_known;
    logic                  start;

    assign start = (state_q == IDLE) && instruction_ready && !ready_prev_q;

    always_comb begin
        dec_we    = '0;
        dec_s0    = SRC_ZERO;
        dec_s1    = SRC_ZERO;
        dec_t0    = TGT_NONE;
        dec_t1    = TGT_NONE;
        dec_known = 1'b1;
        case (instruction_in)
            8'hA9: begin
                dec_s0 = SRC_IMM; dec_t0 = TGT_ADD;
                dec_we[WE_ADD] = 1'b1; dec_we[WE_STAT] = 1'b1;
            end
            8'hA5, 8'hAD: begin
                dec_s0 = SRC_MEM; dec_t0 = TGT_ADD;
                dec_we[WE_ADD] = 1'b1; dec_we[WE_STAT] = 1'b1;
            end
            8'hA2: begin
                dec_s0 = SRC_IMM; dec_t0 = TGT_X;
                dec_we[WE_X] = 1'b1; dec_we[WE_STAT] = 1'b1;
            end
            8'hA6: begin
                dec_s0 = SRC_MEM; dec_t0 = TGT_X;
                dec_we[WE_X] = 1'b1; dec_we[WE_STAT] = 1'b1;
            end
            8'hA0: begin
                dec_s0 = SRC_IMM; dec_t0 = TGT_Y;
                dec_we[WE_Y] = 1'b1; dec_we[WE_STAT] = 1'b1;
            end
            8'hA4: begin
                dec_s0 = SRC_MEM; dec_t0 = TGT_Y;
                dec_we[WE_Y] = 1'b1; dec_we[WE_STAT] = 1'b1;
            end
            8'h85, 8'h8D: begin
                dec_s1 = SRC_ADD; dec_t1 = TGT_MEM;
                dec_we[WE_DOUT] = 1'b1;
            end
            8'h86: begin
                dec_s1 = SRC_X; dec_t1 = TGT_MEM;
                dec_we[WE_DOUT] = 1'b1;
            end
            8'h84: begin
                dec_s1 = SRC_Y; dec_t1 = TGT_MEM;
                dec_we[WE_DOUT] = 1'b1;
            end
            8'hAA: begin
                dec_s0 = SRC_ADD; dec_t0 = TGT_X;
                dec_we[WE_X] = 1'b1; dec_we[WE_STAT] = 1'b1;
            end
            8'hA8: begin
                dec_s0 = SRC_ADD; dec_t0 = TGT_Y;
                dec_we[WE_Y] = 1'b1; dec_we[WE_STAT] = 1'b1;
            end
            8'h8A: begin
                dec_s0 = SRC_X; dec_t0 = TGT_ADD;
                dec_we[WE_ADD] = 1'b1; dec_we[WE_STAT] = 1'b1;
            end
            8'h98: begin
                dec_s0 = SRC_Y; dec_t0 = TGT_ADD;
                dec_we[WE_ADD] = 1'b1; dec_we[WE_STAT] = 1'b1;
            end
            8'hEA, 8'h00: begin
                dec_known = 1'b1;
            end
            default: begin
                dec_known = 1'b0;
            end
        endcase
    end

    // Controls are registered on the detecting edge, so EXEC lasts one cycle
    always_comb begin
        state_d = IDLE;
        opp_d   = opp_q;
        we_d    = '0;
        s0_d    = SRC_ZERO;
        s1_d    = SRC_ZERO;
        t0_d    = TGT_NONE;
        t1_d    = TGT_NONE;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = EXEC;
                    opp_d   = instruction_in;
                    we_d    = dec_we;
                    s0_d    = dec_s0;
                    s1_d    = dec_s1;
                    t0_d    = dec_t0;
                    t1_d    = dec_t1;
                    done_d  = 1'b1;
                end
            end
            EXEC: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ready_prev_q <= 1'b0;
            opp_q        <= '0;
            we_q         <= '0;
            s0_q         <= SRC_ZERO;
            s1_q         <= SRC_ZERO;
            t0_q         <= TGT_NONE;
            t1_q         <= TGT_NONE;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_prev_q <= instruction_ready;
            opp_q        <= opp_d;
            we_q         <= we_d;
            s0_q         <= s0_d;
            s1_q         <= s1_d;
            t0_q         <= t0_d;
            t1_q         <= t1_d;
            done_q       <= done_d;
        end
    end

`ifdef DECODER_ILLEGAL_TRAP_EN
    logic                  illegal_q, illegal_d;
    logic [ADDR_WIDTH-1:0] illegal_addr_q, illegal_addr_d;

    // Only the first illegal opcode's address is kept
    always_comb begin
        illegal_d      = illegal_q;
        illegal_addr_d = illegal_addr_q;
        if (start && !dec_known) begin
            illegal_d = 1'b1;
            if (!illegal_q) begin
                illegal_addr_d = address_in;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_q      <= 1'b0;
            illegal_addr_q <= '0;
        end else begin
            illegal_q      <= illegal_d;
            illegal_addr_q <= illegal_addr_d;
        end
    end

    assign illegal      = illegal_q;
    assign illegal_addr = illegal_addr_q;
`else
    logic unused_trap;
    assign unused_trap = dec_known ^ (^address_in);
`endif

    assign opp               = opp_q;
    assign we                = we_q;
    assign source_selector_0 = s0_q;
    assign source_selector_1 = s1_q;
    assign target_selector_0 = t0_q;
    assign target_selector_1 = t1_q;
    assign instruction_done  = done_q;

endmodule

// File: tb/tb_instruction_decoder.sv
// Table-driven bench for instruction_decoder plus hand sequences for
// retrigger suppression and asynchronous reset during EXEC.
module tb_instruction_decoder;

    logic        clk;
    logic        reset;
    logic        instruction_ready;
    logic [7:0]  instruction_in;
    logic [15:0] address_in;
    logic [7:0]  opp;
    logic [6:0]  we;
    logic [2:0]  source_selector_0, source_selector_1;
    logic [2:0]  target_selector_0, target_selector_1;
    logic        instruction_done;
`ifdef DECODER_ILLEGAL_TRAP_EN
    logic        illegal;
    logic [15:0] illegal_addr;
`endif

    instruction_decoder dut (
        .clk               (clk),
        .reset             (reset),
        .instruction_ready (instruction_ready),
        .instruction_in    (instruction_in),
        .address_in        (address_in),
        .opp               (opp),
        .we                (we),
        .source_selector_0 (source_selector_0),
        .source_selector_1 (source_selector_1),
        .target_selector_0 (target_selector_0),
        .target_selector_1 (target_selector_1),
`ifdef DECODER_ILLEGAL_TRAP_EN
        .illegal           (illegal),
        .illegal_addr      (illegal_addr),
`endif
        .instruction_done  (instruction_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] op;
        logic [6:0] we;
        logic [2:0] s0;
        logic [2:0] t0;
        logic [2:0] s1;
        logic [2:0] t1;
        logic       legal;
    } vec_t;

    vec_t tbl[20];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input logic [7:0] op, input logic [6:0] w,
                                input logic [2:0] s0, input logic [2:0] t0,
                                input logic [2:0] s1, input logic [2:0] t1,
                                input logic legal);
        vec_t v;
        v.op = op; v.we = w; v.s0 = s0; v.t0 = t0;
        v.s1 = s1; v.t1 = t1; v.legal = legal;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".we"}, {25'd0, we}, 32'h0);
        chk({tag, ".s0"}, {29'd0, source_selector_0}, 32'd6);
        chk({tag, ".t0"}, {29'd0, target_selector_0}, 32'd4);
        chk({tag, ".s1"}, {29'd0, source_selector_1}, 32'd6);
        chk({tag, ".t1"}, {29'd0, target_selector_1}, 32'd4);
        chk({tag, ".done"}, {31'd0, instruction_done}, 32'd0);
    endtask

    // Raise ready with an opcode; returns #1 after the detecting edge
    task automatic issue(input logic [7:0] op, input logic [15:0] addr);
        instruction_in    = op;
        address_in        = addr;
        instruction_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic exp_ill;
        logic [15:0] a;
        string nm;

        tbl[0]  = mk(8'hA9, 7'h24, 3'd4, 3'd1, 3'd6, 3'd4, 1'b1);
        tbl[1]  = mk(8'hA5, 7'h24, 3'd5, 3'd1, 3'd6, 3'd4, 1'b1);
        tbl[2]  = mk(8'hAD, 7'h24, 3'd5, 3'd1, 3'd6, 3'd4, 1'b1);
        tbl[3]  = mk(8'hA2, 7'h28, 3'd4, 3'd2, 3'd6, 3'd4, 1'b1);
        tbl[4]  = mk(8'hA6, 7'h28, 3'd5, 3'd2, 3'd6, 3'd4, 1'b1);
        tbl[5]  = mk(8'hA0, 7'h30, 3'd4, 3'd3, 3'd6, 3'd4, 1'b1);
        tbl[6]  = mk(8'hA4, 7'h30, 3'd5, 3'd3, 3'd6, 3'd4, 1'b1);
        tbl[7]  = mk(8'h85, 7'h40, 3'd6, 3'd4, 3'd1, 3'd5, 1'b1);
        tbl[8]  = mk(8'h8D, 7'h40, 3'd6, 3'd4, 3'd1, 3'd5, 1'b1);
        tbl[9]  = mk(8'h86, 7'h40, 3'd6, 3'd4, 3'd2, 3'd5, 1'b1);
        tbl[10] = mk(8'h84, 7'h40, 3'd6, 3'd4, 3'd3, 3'd5, 1'b1);
        tbl[11] = mk(8'hAA, 7'h28, 3'd1, 3'd2, 3'd6, 3'd4, 1'b1);
        tbl[12] = mk(8'hA8, 7'h30, 3'd1, 3'd3, 3'd6, 3'd4, 1'b1);
        tbl[13] = mk(8'h8A, 7'h24, 3'd2, 3'd1, 3'd6, 3'd4, 1'b1);
        tbl[14] = mk(8'h98, 7'h24, 3'd3, 3'd1, 3'd6, 3'd4, 1'b1);
        tbl[15] = mk(8'hEA, 7'h00, 3'd6, 3'd4, 3'd6, 3'd4, 1'b1);
        tbl[16] = mk(8'h00, 7'h00, 3'd6, 3'd4, 3'd6, 3'd4, 1'b1);
        tbl[17] = mk(8'hFF, 7'h00, 3'd6, 3'd4, 3'd6, 3'd4, 1'b0);
        tbl[18] = mk(8'h13, 7'h00, 3'd6, 3'd4, 3'd6, 3'd4, 1'b0);
        tbl[19] = mk(8'hB5, 7'h00, 3'd6, 3'd4, 3'd6, 3'd4, 1'b0);

        reset             = 1'b0;
        instruction_ready = 1'b0;
        instruction_in    = 8'h00;
        address_in        = 16'h0000;

        // Reset asserted mid-clock, checked before any edge
        #3 reset = 1'b1;
        #1;
        chk_idle("rst");
        chk("rst.opp", {24'd0, opp}, 32'h0);
`ifdef DECODER_ILLEGAL_TRAP_EN
        chk("rst.illegal", {31'd0, illegal}, 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_idle("post_rst");

        exp_ill = 1'b0;
        foreach (tbl[i]) begin
            a = (tbl[i].op == 8'hFF) ? 16'h0010 : {8'h01, tbl[i].op};
            nm = $sformatf("op%02h", tbl[i].op);
            issue(tbl[i].op, a);
            if (!tbl[i].legal) exp_ill = 1'b1;
            chk({nm, ".opp"}, {24'd0, opp}, {24'd0, tbl[i].op});
            chk({nm, ".we"}, {25'd0, we}, {25'd0, tbl[i].we});
            chk({nm, ".s0"}, {29'd0, source_selector_0}, {29'd0, tbl[i].s0});
            chk({nm, ".t0"}, {29'd0, target_selector_0}, {29'd0, tbl[i].t0});
            chk({nm, ".s1"}, {29'd0, source_selector_1}, {29'd0, tbl[i].s1});
            chk({nm, ".t1"}, {29'd0, target_selector_1}, {29'd0, tbl[i].t1});
            chk({nm, ".done"}, {31'd0, instruction_done}, 32'd1);
`ifdef DECODER_ILLEGAL_TRAP_EN
            chk({nm, ".illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
            if (exp_ill)
                chk({nm, ".ill_addr"}, {16'd0, illegal_addr}, 32'h0010);
`endif
            instruction_ready = 1'b0;
            @(posedge clk);
            #1;
            chk_idle({nm, ".idle"});
        end

`ifdef DECODER_ILLEGAL_TRAP_EN
        issue(8'hA9, 16'h0200);
        instruction_ready = 1'b0;
        chk("sticky.illegal", {31'd0, illegal}, 32'd1);
        chk("sticky.addr", {16'd0, illegal_addr}, 32'h0010);
        @(posedge clk);
        #1;
`endif

        // Ready held high: one pulse only, then re-raise gives a second
        issue(8'hAA, 16'h0300);
        chk("hold.s0", {29'd0, source_selector_0}, 32'd1);
        chk("hold.t0", {29'd0, target_selector_0}, 32'd2);
        chk("hold.we", {25'd0, we}, 32'h28);
        cnt = instruction_done ? 1 : 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (instruction_done) cnt++;
        end
        chk("hold.pulses", cnt, 32'd1);
        instruction_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        instruction_ready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (instruction_done) cnt++;
        end
        chk("reraise.pulses", cnt, 32'd1);
        instruction_ready = 1'b0;
        @(posedge clk);
        #1;

        // Asynchronous reset in the EXEC cycle of A2
        issue(8'hA2, 16'h0400);
        chk("a2.done", {31'd0, instruction_done}, 32'd1);
        chk("a2.we", {25'd0, we}, 32'h28);
        instruction_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk_idle("exec_rst");
        chk("exec_rst.opp", {24'd0, opp}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (instruction_done) cnt++;
        end
        chk("after_rst.no_done", cnt, 32'd0);
        issue(8'hA9, 16'h0500);
        chk("after_rst.done", {31'd0, instruction_done}, 32'd1);
        chk("after_rst.s0", {29'd0, source_selector_0}, 32'd4);
        instruction_ready = 1'b0;
        @(posedge clk);
        #1;
        chk_idle("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
